// File: rtl/fifo_arb_pkg.sv
// Shared types and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Bits needed to index n distinct values; never narrower than 1.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Circular priority select: first set bit of req at or after ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any_valid
);

  int          s;
  logic [W-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx       = '0;
    any_valid = |req;
    s         = 0;
    j         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      j = W'(s);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ burst sources.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_SIZE = 32,
  parameter  int MAX_BURST = 16,
  localparam int GW        = width_of(NUM_REQ),
  localparam int BW        = width_of(MAX_BURST + 1)
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wdata,
  input  logic                         wfull,
  output logic [GW-1:0]                gnt_id,
  output logic                         gnt_active
);

  arb_state_e    state;
  logic [GW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          busy;
  logic          accept;
  logic          burst_end;

  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign busy       = (state == ST_BUSY);
  assign gnt_active = busy;
  assign accept     = busy & req_valid[gnt_id] & ~wfull;
  // The cap test uses the pre-increment count: this beat makes MAX_BURST.
  assign burst_end  = accept & (req_last[gnt_id] | (beat_cnt == BW'(MAX_BURST - 1)));
  assign winc       = accept;
  assign wdata      = busy ? req_data[gnt_id*DATA_SIZE +: DATA_SIZE] : '0;

  always_comb begin
    req_ready = '0;
    if (busy && !wfull) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_any) begin
          state    <= ST_BUSY;
          gnt_id   <= pick_idx;
          beat_cnt <= '0;
        end
        ST_BUSY: if (accept) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (burst_end) begin
            state  <= ST_IDLE;
            rr_ptr <= (gnt_id == GW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts each cycle's write port.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int GW = $clog2(N);

  logic              wclk = 1'b0;
  logic              wrst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_last = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic              wfull = 1'b0;
  logic [GW-1:0]     gnt_id;
  logic              gnt_active;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .winc(winc), .wdata(wdata),
    .wfull(wfull), .gnt_id(gnt_id), .gnt_active(gnt_active)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic          winc;
    logic [DW-1:0] wdata;
    logic [N-1:0]  ready;
    logic          act;
    logic [GW-1:0] gid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // producers: each emits a numbered stream cut into bursts of rem beats
  int seq[N];
  int rem[N];
  // reference model: who holds the port, beats taken, where the search starts
  int m_busy, m_gnt, m_cnt, m_ptr;
  // phase knobs
  logic [N-1:0] vmask;
  int pv, pfull, blo, bhi;
  int want_full, full_hold, want_drop, drop_hold, drop_id, want_rst, rst_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_cnt = 0; m_ptr = 0;
  endtask

  // Apply the edge that just happened using the inputs that were presented before it.
  task automatic step();
    int j;
    if (!wrst_n) return;
    if (m_busy == 0) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (req_valid[j]) begin
          m_busy = 1; m_gnt = j; m_cnt = 0;
          break;
        end
      end
    end else if (req_valid[m_gnt] && !wfull) begin
      m_cnt++;
      if (req_last[m_gnt] || m_cnt == MB) begin
        m_busy = 0;
        m_ptr  = (m_gnt + 1) % N;
      end
      seq[m_gnt]++;
      rem[m_gnt]--;
    end
  endtask

  task automatic drive();
    exp_t e;
    if (want_full != 0 && m_busy != 0) begin full_hold = 5; want_full = 0; end
    if (want_drop != 0 && m_busy != 0 && m_gnt != 0) begin
      drop_hold = 3; drop_id = m_gnt; want_drop = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (rem[i] <= 0) rem[i] = $urandom_range(bhi, blo);
      req_valid[i] = vmask[i] && ($urandom_range(99) < pv);
      req_last[i]  = (rem[i] == 1);
      req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
    end
    if (drop_hold > 0) begin
      req_valid[drop_id] = 1'b0;
      req_valid[0]       = 1'b1;
      drop_hold--;
    end
    if (full_hold > 0) begin
      wfull = 1'b1; full_hold--;
    end else begin
      wfull = ($urandom_range(99) < pfull);
    end
    e.act = (m_busy != 0); e.gid = GW'(m_gnt);
    e.winc = 1'b0; e.wdata = '0; e.ready = '0;
    if (m_busy != 0) begin
      e.wdata = req_data[m_gnt*DW +: DW];
      if (!wfull) begin
        e.ready[m_gnt] = 1'b1;
        e.winc = req_valid[m_gnt];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge wclk);
      #2;
      step();
      if (want_rst != 0 && m_busy != 0 && m_cnt > 0) begin rst_cnt = 2; want_rst = 0; end
      if (rst_cnt > 0) begin
        wrst_n = 1'b0;
        rst_cnt--;
        model_reset();
        #1;
        chk("async_rst_winc", 64'(winc), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        chk("async_rst_wdata", 64'(wdata), 64'd0);
        chk("async_rst_active", 64'(gnt_active), 64'd0);
      end else begin
        wrst_n = 1'b1;
      end
      drive();
    end
  endtask

  task automatic phase(input logic [N-1:0] m, input int p_v, input int p_f,
                       input int lo, input int hi, input int cycles);
    vmask = m; pv = p_v; pfull = p_f; blo = lo; bhi = hi;
    for (int i = 0; i < N; i++) rem[i] = 0;
    run(cycles);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("winc", 64'(winc), 64'(e.winc));
        chk("req_ready", 64'(req_ready), 64'(e.ready));
        chk("gnt_active", 64'(gnt_active), 64'(e.act));
        chk("gnt_id", 64'(gnt_id), 64'(e.gid));
        if (e.act) chk("wdata", 64'(wdata), 64'(e.wdata));
        else       chk("wdata_idle", 64'(wdata), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin seq[i] = 0; rem[i] = 0; end
    model_reset();
    vmask = '0; pv = 0; pfull = 0; blo = 1; bhi = 1;
    want_full = 0; full_hold = 0; want_drop = 0; drop_hold = 0; drop_id = 0;
    want_rst = 0; rst_cnt = 3;
    #1;
    chk("reset_winc", 64'(winc), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_active", 64'(gnt_active), 64'd0);
    chk("reset_gnt_id", 64'(gnt_id), 64'd0);
    run(4);
    // single requester 2, 3-beat bursts
    phase(4'b0100, 100, 0, 3, 3, 5);
    phase(4'b0000, 0, 0, 1, 1, 3);
    // everyone always valid, one-beat bursts: strict rotation with bubbles
    phase(4'b1111, 100, 0, 1, 1, 24);
    // requester 1 alone with oversized bursts: capped at MAX_BURST
    phase(4'b0010, 100, 0, 20, 20, 45);
    // a 5-cycle full window in the middle of a burst
    want_full = 1;
    phase(4'b1111, 100, 0, 6, 10, 30);
    // grantee stalls while requester 0 waits
    want_drop = 1;
    phase(4'b1111, 100, 0, 6, 10, 30);
    // random traffic with backpressure
    phase(4'b1111, 70, 20, 1, 20, 300);
    // reset mid-burst, arbitration restarts at requester 0
    want_rst = 1;
    phase(4'b1111, 90, 10, 2, 12, 60);
    @(negedge wclk);
    #1;
    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
